// File: rtl/pc_gen.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing, +PC_STEP advance, execute redirects.
// Optional performance counters are compiled in when PCGEN_PERF_EN is defined.
module pc_gen #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] inst_addr,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  input  logic            halt_req,
  output logic            halted,
  output logic            misalign_err
`ifdef PCGEN_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_redirect_cnt
`endif
);

  localparam logic [XLEN-1:0] RESET_ADDR = RESET_PC[XLEN-1:0];
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic            flush_reg, flush_next;
  logic            mis_reg, mis_next;
  logic            fire;
  logic            misaligned;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign fire       = (state_reg == RUN) && pc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
      addr_reg  <= RESET_ADDR;
      flush_reg <= 1'b0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      flush_reg <= flush_next;
      mis_reg   <= mis_next;
    end
  end

  // Priority inside BOOT/RUN: halt_req, misaligned redirect, aligned redirect, advance.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    flush_next = 1'b0;
    mis_next   = mis_reg;
    case (state_reg)
      BOOT, RUN: begin
        if (state_reg == BOOT) state_next = RUN;
        if (halt_req) begin
          state_next = HALT;
        end else if (redirect_valid && misaligned) begin
          state_next = HALT;
          mis_next   = 1'b1;
          flush_next = 1'b1;
        end else if (redirect_valid) begin
          addr_next  = redirect_pc;
          flush_next = 1'b1;
        end else if (fire) begin
          addr_next  = addr_reg + STEP;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign inst_addr    = addr_reg;
  assign pc_valid     = (state_reg == RUN);
  assign halted       = (state_reg == HALT);
  assign flush        = flush_reg;
  assign misalign_err = mis_reg;

`ifdef PCGEN_PERF_EN
  logic redir_taken;
  logic [63:0] fetch_cnt_reg, redirect_cnt_reg;

  // HALT never fires or takes a redirect, so both counters freeze there naturally.
  assign redir_taken = (state_reg != HALT) && !halt_req && redirect_valid && !misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg    <= 64'd0;
      redirect_cnt_reg <= 64'd0;
    end else begin
      if (fire)        fetch_cnt_reg    <= fetch_cnt_reg + 64'd1;
      if (redir_taken) redirect_cnt_reg <= redirect_cnt_reg + 64'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_reg;
  assign perf_redirect_cnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven scoreboard bench for pc_gen (XLEN=32 build).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr;
  logic        pc_valid;
  logic        pc_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        flush;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        misalign_err;
`ifdef PCGEN_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_redirect_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_PC(64'h8000_0000), .PC_STEP(4)) dut (
    .clk(clk),
    .rst(rst),
    .inst_addr(inst_addr),
    .pc_valid(pc_valid),
    .pc_ready(pc_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
    .halt_req(halt_req),
    .halted(halted),
    .misalign_err(misalign_err)
`ifdef PCGEN_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  // Inputs are applied for one cycle; expected fields describe the outputs seen in that same cycle.
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        hrq;
    logic        chk;
    logic        fchk;
    logic [31:0] addr;
    logic        valid;
    logic        flush;
    logic        halted;
    logic        mis;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   vec_no = 0;

  function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rpc, logic hrq,
                              logic chk, logic fchk, logic [31:0] addr, logic valid,
                              logic fl, logic hl, logic mis);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hrq = hrq;
    v.chk = chk; v.fchk = fchk; v.addr = addr; v.valid = valid;
    v.flush = fl; v.halted = hl; v.mis = mis;
    return v;
  endfunction

  task automatic check_bit(string name, logic got, logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s got %b exp %b", vec_no, name, got, exp);
    end
  endtask

  task automatic step(vec_t v);
    vec_t e;
    @(negedge clk);
    rst            = v.rst;
    pc_ready       = v.rdy;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    halt_req       = v.hrq;
    if (v.chk) sb.push_back(v);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if (inst_addr !== e.addr) begin
        n_fail++;
        $display("FAIL v%0d inst_addr got %h exp %h", vec_no, inst_addr, e.addr);
      end
      check_bit("pc_valid", pc_valid, e.valid);
      check_bit("halted", halted, e.halted);
      check_bit("misalign_err", misalign_err, e.mis);
      if (e.fchk) check_bit("flush", flush, e.flush);
      $display("v%0d rst=%b rdy=%b rv=%b rpc=%h hrq=%b -> addr=%h valid=%b flush=%b halted=%b mis=%b",
               vec_no, v.rst, v.rdy, v.rv, v.rpc, v.hrq, inst_addr, pc_valid, flush, halted,
               misalign_err);
    end
    vec_no++;
  endtask

  initial begin
    //          rst rdy rv rpc           hrq chk fchk addr          vld fl hl mis
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0000, 0, 0, 0, 0)); // BOOT
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0008, 1, 0, 0, 0)); // stall
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0008, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0008, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0008, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h8000_1000, 0, 1, 1, 32'h8000_000C, 1, 0, 0, 0)); // redirect, stalled
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_1000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_1000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h8000_2000, 0, 1, 1, 32'h8000_1004, 1, 0, 0, 0)); // redirect beats advance
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_2000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h8000_1002, 0, 1, 1, 32'h8000_2004, 1, 0, 0, 0)); // misaligned
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_2004, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 32'h8000_3000, 1, 1, 1, 32'h8000_2004, 0, 0, 1, 1)); // HALT ignores inputs
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_2004, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h8000_2004, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0000, 0, 0, 0, 0)); // rst held: BOOT
    tbl.push_back(mk(0, 0, 1, 32'h8000_4000, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 0)); // redirect in BOOT
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_4000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h8000_1002, 1, 1, 1, 32'h8000_4000, 1, 0, 0, 0)); // halt + misaligned
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 0, 32'h8000_4000, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h8000_4000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0000, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h8000_5000, 0, 1, 1, 32'h8000_0000, 1, 0, 0, 0)); // rst beats redirect
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 32'h8000_0000, 0, 0, 0, 0)); // halt in BOOT
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h8000_0000, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Wrap-around: redirect to the last word during BOOT, then accept twice.
    step(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 1, 1, 32'h8000_0000, 0, 0, 0, 0));
    step(mk(0, 1, 0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 1, 1, 0, 0));
    step(mk(0, 1, 0, 32'h0,         0, 1, 1, 32'h0000_0000, 1, 0, 0, 0));
    step(mk(0, 0, 0, 32'h0,         0, 1, 1, 32'h0000_0004, 1, 0, 0, 0));
`ifdef PCGEN_PERF_EN
    n_checks++;
    if (perf_fetch_cnt !== 64'd2) begin
      n_fail++;
      $display("FAIL perf_fetch_cnt got %0d exp 2", perf_fetch_cnt);
    end
    n_checks++;
    if (perf_redirect_cnt !== 64'd1) begin
      n_fail++;
      $display("FAIL perf_redirect_cnt got %0d exp 1", perf_redirect_cnt);
    end
`endif
    step(mk(0, 0, 0, 32'h0,         0, 1, 1, 32'h0000_0004, 1, 0, 0, 0));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard %0d entries left exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
